// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan sequencer: per-slot blanking, hex decode with
// leading-zero suppression, and a pending/shadow buffer committed on frame wrap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | timer in 0..BLANK_CYC-1, all segments and digits inactive
// ST_SHOW  | timer in BLANK_CYC..SCAN_DIV-1, current digit driven
module seg_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp,
    input  logic        load,
    input  logic [7:0]  en_mask,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic        seg_dp,
    output logic [7:0]  dig_sel,
    output logic [2:0]  dig_idx,
    output logic        upd_pend,
    output logic        frame_done
);

    localparam int TW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(SCAN_DIV - 1);
    localparam logic [TW-1:0] T_SHOW = TW'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]  idx_n;
    logic [31:0] shadow_data, shadow_data_n, pend_data, pend_data_n;
    logic [7:0]  shadow_dp, shadow_dp_n, pend_dp, pend_dp_n;
    logic        upd_pend_n;
    logic        slot_end, frame_wrap;
    logic        show, lz_blank;
    logic [3:0]  nib;
    logic [6:0]  seg_ah;
    logic        dp_ah;
    logic [7:0]  dig_ah;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        slot_end   = (timer == T_LAST);
        frame_wrap = slot_end && (dig_idx == 3'd7);
        timer_n    = slot_end ? '0 : timer + TW'(1);
        idx_n      = slot_end ? dig_idx + 3'd1 : dig_idx;

        state_n = state;
        if (slot_end)
            state_n = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
        else if (state == ST_BLANK && timer_n >= T_SHOW)
            state_n = ST_SHOW;

        shadow_data_n = shadow_data;
        shadow_dp_n   = shadow_dp;
        pend_data_n   = pend_data;
        pend_dp_n     = pend_dp;
        upd_pend_n    = upd_pend;
        // A load landing on the wrap edge bypasses pending and shows immediately.
        if (frame_wrap && load) begin
            shadow_data_n = data;
            shadow_dp_n   = dp;
            pend_data_n   = data;
            pend_dp_n     = dp;
            upd_pend_n    = 1'b0;
        end else if (frame_wrap && upd_pend) begin
            shadow_data_n = pend_data;
            shadow_dp_n   = pend_dp;
            upd_pend_n    = 1'b0;
        end else if (load) begin
            pend_data_n = data;
            pend_dp_n   = dp;
            upd_pend_n  = 1'b1;
        end

        show     = (state_n == ST_SHOW) && en_mask[idx_n];
        lz_blank = lz_en && (idx_n != 3'd0) &&
                   ((shadow_data_n >> {idx_n, 2'b00}) == 32'd0);
        nib      = shadow_data_n[{idx_n, 2'b00} +: 4];
        seg_ah   = (show && !lz_blank) ? hex7(nib) : 7'h00;
        dp_ah    = show && shadow_dp_n[idx_n];
        dig_ah   = show ? (8'd1 << idx_n) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BLANK;
            timer       <= '0;
            dig_idx     <= 3'd0;
            shadow_data <= 32'd0;
            shadow_dp   <= 8'd0;
            pend_data   <= 32'd0;
            pend_dp     <= 8'd0;
            upd_pend    <= 1'b0;
            frame_done  <= 1'b0;
            seg         <= {7{SEG_ACTIVE_LOW}};
            seg_dp      <= SEG_ACTIVE_LOW;
            dig_sel     <= {8{DIG_ACTIVE_LOW}};
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            dig_idx     <= idx_n;
            shadow_data <= shadow_data_n;
            shadow_dp   <= shadow_dp_n;
            pend_data   <= pend_data_n;
            pend_dp     <= pend_dp_n;
            upd_pend    <= upd_pend_n;
            frame_done  <= frame_wrap;
            seg         <= SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
            seg_dp      <= SEG_ACTIVE_LOW ? ~dp_ah : dp_ah;
            dig_sel     <= DIG_ACTIVE_LOW ? ~dig_ah : dig_ah;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg_scan_ctrl;

    localparam int SD    = 4;
    localparam int BC    = 1;
    localparam int FRAME = 8 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = 32'd0;
    logic [7:0]  dp = 8'd0;
    logic        load = 1'b0;
    logic [7:0]  en_mask = 8'hFF;
    logic        lz_en = 1'b0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [7:0]  dig_sel;
    logic [2:0]  dig_idx;
    logic        upd_pend;
    logic        frame_done;

    seg_scan_ctrl #(
        .SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .load(load),
        .en_mask(en_mask), .lz_en(lz_en), .seg(seg), .seg_dp(seg_dp),
        .dig_sel(dig_sel), .dig_idx(dig_idx), .upd_pend(upd_pend),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: position in the frame is just a count of cycles since reset.
    int          m_c = 0;
    bit          mvalid = 0;
    logic [31:0] m_sh = 0, m_pd = 0;
    logic [7:0]  m_shdp = 0, m_pdp = 0;
    logic        m_flag = 0, m_fd = 0;
    logic [6:0]  e_seg = 7'h7F;
    logic        e_dp = 1'b1;
    logic [7:0]  e_dig = 8'hFF;
    logic [2:0]  e_idx = 3'd0;
    logic        e_upd = 1'b0;

    always @(posedge clk) begin
        int  slot, pos;
        bit  show, allz, sup;
        if (rst) begin
            m_c = 0; m_sh = 0; m_shdp = 0; m_pd = 0; m_pdp = 0;
            m_flag = 0; m_fd = 0;
        end else begin
            m_c = m_c + 1;
            m_fd = ((m_c % FRAME) == 0);
            if (m_fd && load) begin
                m_sh = data; m_shdp = dp; m_flag = 0;
            end else if (m_fd && m_flag) begin
                m_sh = m_pd; m_shdp = m_pdp; m_flag = 0;
            end else if (load) begin
                m_pd = data; m_pdp = dp; m_flag = 1;
            end
        end
        slot = (m_c / SD) % 8;
        pos  = m_c % SD;
        show = (pos >= BC) && en_mask[slot];
        allz = 1;
        for (int k = 7; k >= slot; k--)
            if (m_sh[4*k +: 4] != 4'd0) allz = 0;
        sup  = lz_en && (slot != 0) && allz;
        e_seg = ~((show && !sup) ? dec_tab[m_sh[4*slot +: 4]] : 7'h00);
        e_dp  = ~(show && m_shdp[slot]);
        e_dig = ~(show ? (8'd1 << slot) : 8'd0);
        e_idx = 3'(slot);
        e_upd = m_flag;
        mvalid = 1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            total = total + 1;
            if (seg !== e_seg || seg_dp !== e_dp || dig_sel !== e_dig ||
                dig_idx !== e_idx || upd_pend !== e_upd || frame_done !== m_fd) begin
                bad = bad + 1;
                $display("FAIL model t=%0t got seg=%h dp=%b dig=%h idx=%0d upd=%b fd=%b want seg=%h dp=%b dig=%h idx=%0d upd=%b fd=%b",
                         $time, seg, seg_dp, dig_sel, dig_idx, upd_pend, frame_done,
                         e_seg, e_dp, e_dig, e_idx, e_upd, m_fd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h want=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dig", 32'(dig_sel), 32'hFF);
        chk("rst_idx", 32'(dig_idx), 32'h0);
        chk("rst_upd", 32'(upd_pend), 32'h0);
        rst = 1'b0; cyc = 0;
        goto(1);  chk("c1_dig", 32'(dig_sel), 32'hFE);
        goto(3);  chk("c3_dig", 32'(dig_sel), 32'hFE);
        goto(4);  chk("c4_dig", 32'(dig_sel), 32'hFF);
        goto(5);  chk("c5_dig", 32'(dig_sel), 32'hFD);
        goto(31); chk("c31_fd", 32'(frame_done), 32'h0);
        goto(32); chk("c32_fd", 32'(frame_done), 32'h1);
        chk("c32_idx", 32'(dig_idx), 32'h0);

        data = 32'h000000A5; dp = 8'h00; load = 1'b1; lz_en = 1'b1; en_mask = 8'hFF;
        goto(33); load = 1'b0;
        for (int s = 0; s < 8; s++) begin
            goto(64 + 4*s + 1);
            chk("lz_seg", 32'(seg), (s >= 2) ? 32'h7F : (s == 1) ? 32'h08 : 32'h12);
        end
        lz_en = 1'b0;
        goto(105); chk("nolz_seg2", 32'(seg), 32'h40);

        goto(109); data = 32'h12345678; load = 1'b1;
        goto(110); load = 1'b0; chk("def_upd1", 32'(upd_pend), 32'h1);
        goto(125); chk("def_old7", 32'(seg), 32'h40);
        chk("def_upd7", 32'(upd_pend), 32'h1);
        goto(128); chk("def_upd0", 32'(upd_pend), 32'h0);
        chk("def_fd", 32'(frame_done), 32'h1);
        goto(129); chk("def_dig0", 32'(seg), 32'h00);
        goto(133); chk("def_dig1", 32'(seg), 32'h78);

        goto(159); data = 32'h0000000C; load = 1'b1;
        goto(160); load = 1'b0; chk("edge_upd", 32'(upd_pend), 32'h0);
        goto(161); chk("edge_seg", 32'(seg), 32'h46);
        goto(165); data = 32'h1; load = 1'b1;
        goto(166); data = 32'h2;
        goto(167); load = 1'b0;
        goto(193); chk("b2b_seg", 32'(seg), 32'h24);
        chk("b2b_upd", 32'(upd_pend), 32'h0);

        goto(220); en_mask = 8'hFE;
        goto(223); chk("mask_idx7", 32'(dig_idx), 32'h7);
        for (int k = 0; k < 4; k++) begin
            goto(224 + k);
            chk("mask_dig", 32'(dig_sel), 32'hFF);
            chk("mask_idx", 32'(dig_idx), 32'h0);
            chk("mask_fd", 32'(frame_done), (k == 0) ? 32'h1 : 32'h0);
        end
        en_mask = 8'hFF;

        goto(276); data = 32'hFFFFFFFF; load = 1'b1;
        goto(277); load = 1'b0; chk("mid_upd", 32'(upd_pend), 32'h1);
        rst = 1'b1;
        goto(278);
        chk("mid_seg", 32'(seg), 32'h7F);
        chk("mid_dig", 32'(dig_sel), 32'hFF);
        chk("mid_idx", 32'(dig_idx), 32'h0);
        chk("mid_upd0", 32'(upd_pend), 32'h0);
        rst = 1'b0; cyc = 0;
        goto(1);  chk("post_seg", 32'(seg), 32'h40);
        goto(33); chk("post_wrap_seg", 32'(seg), 32'h40);
        chk("post_wrap_upd", 32'(upd_pend), 32'h0);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 7) == 0);
            data = $urandom >> (4 * $urandom_range(0, 8));
            dp   = 8'($urandom);
            if ($urandom_range(0, 15) == 0) en_mask = 8'($urandom);
            if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0; load = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
